// File: rtl/machine_controller.sv
// Eight-slot instruction-cycle sequencer for the 8-bit RISC CPU.
// Optional MACHINE_CTRL_HALT_LATCH_EN makes HLT a sticky halt state.
module machine_controller #(
  parameter int OP_W  = 3,
  parameter int NSLOT = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ena,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            inc_pc,
  output logic            load_acc,
  output logic            load_pc,
  output logic            rd,
  output logic            wr,
  output logic            load_ir,
  output logic            datactl_ena,
  output logic            halt,
  output logic [2:0]      slot
);

  localparam logic [OP_W-1:0] OP_HLT  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SKZ  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ANDD = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XORR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDA  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STO  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(7);

  localparam logic [2:0] SLOT_LAST = 3'(NSLOT - 1);

  typedef struct packed {
    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic datactl_ena;
    logic halt;
  } strb_t;

  logic [2:0] slot_q, slot_d;
  strb_t      strb_q, strb_d;
  strb_t      dec;

  logic is_alu;
  logic is_skz1;
  logic is_hlt;

  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                   (opcode == OP_XORR) || (opcode == OP_LDA);
  assign is_skz1 = (opcode == OP_SKZ) && zero;
  assign is_hlt  = (opcode == OP_HLT);

  // Output decode: strobes for the slot being sampled this edge.
  always_comb begin
    dec = '0;
    case (slot_q)
      3'd0: begin
        dec.rd      = 1'b1;
        dec.load_ir = 1'b1;
        dec.inc_pc  = 1'b1;
      end
      3'd1: begin
        dec.rd      = 1'b1;
        dec.load_ir = 1'b1;
      end
      3'd2: dec = '0;
      3'd3: begin
        dec.inc_pc = 1'b1;
        dec.halt   = is_hlt;
      end
      3'd4: begin
        dec.load_pc     = (opcode == OP_JMP);
        dec.rd          = is_alu;
        dec.datactl_ena = (opcode == OP_STO);
      end
      3'd5: begin
        dec.rd          = is_alu;
        dec.load_acc    = is_alu;
        dec.inc_pc      = is_skz1 || (opcode == OP_JMP);
        dec.load_pc     = (opcode == OP_JMP);
        dec.wr          = (opcode == OP_STO);
        dec.datactl_ena = (opcode == OP_STO);
      end
      3'd6: begin
        dec.rd          = is_alu;
        dec.inc_pc      = is_skz1;
        dec.datactl_ena = (opcode == OP_STO);
      end
      3'd7: dec.inc_pc = is_skz1;
      default: dec = '0;
    endcase
  end

`ifdef MACHINE_CTRL_HALT_LATCH_EN
  logic halted_q, halted_d;

  always_comb begin
    slot_d   = 3'd0;
    strb_d   = '0;
    halted_d = halted_q;
    if (halted_q) begin
      slot_d      = 3'd4;
      strb_d.halt = 1'b1;
    end else if (ena) begin
      if (slot_q == 3'd3 && is_hlt) begin
        halted_d    = 1'b1;
        slot_d      = 3'd4;
        strb_d.halt = 1'b1;
      end else begin
        strb_d = dec;
        slot_d = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q   <= 3'd0;
      strb_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      strb_q   <= strb_d;
      halted_q <= halted_d;
    end
  end
`else
  always_comb begin
    slot_d = 3'd0;
    strb_d = '0;
    if (ena) begin
      strb_d = dec;
      slot_d = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= 3'd0;
      strb_q <= '0;
    end else begin
      slot_q <= slot_d;
      strb_q <= strb_d;
    end
  end
`endif

  assign inc_pc      = strb_q.inc_pc;
  assign load_acc    = strb_q.load_acc;
  assign load_pc     = strb_q.load_pc;
  assign rd          = strb_q.rd;
  assign wr          = strb_q.wr;
  assign load_ir     = strb_q.load_ir;
  assign datactl_ena = strb_q.datactl_ena;
  assign halt        = strb_q.halt;
  assign slot        = slot_q;

endmodule
